// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default rates and the
// oversampling divider calculation used by both RX and TX.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ = 50_000_000;
  localparam int unsigned UART_BAUD     = 115_200;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversampling tick, rounded to nearest, never below 1.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    longint unsigned q;
    den = 64'(baud) * 64'(os);
    if (den == 64'd0) return 1;
    q = (64'(clk_freq) + den / 64'd2) / den;
    if (q < 64'd1) q = 64'd1;
    return 32'(q);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned  CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; clr realigns the phase.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// UART 8N1 receiver with oversampled majority-vote bit sampling and a
// valid/ready output handshake.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
  parameter int unsigned BAUD       = UART_BAUD,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned PW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S2  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LASTBIT = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 sync1, rxs, rxs_d;
  logic                 tick;
  logic [PW-1:0]        phase;
  logic [BW-1:0]        bitcnt;
  logic                 samp0, samp1;
  logic                 bit_val, data_pend;
  logic [DATA_BITS-1:0] shreg;
  logic                 maj, fall, mid, bit_end, load, stop_bad;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (tick)
  );

  assign maj      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign fall     = rxs_d & ~rxs;
  assign mid      = tick && (phase == PH_S2);
  assign bit_end  = tick && (phase == PH_END);
  assign load     = (state == STOP) && mid && maj;
  assign stop_bad = (state == STOP) && mid && !maj;
  assign busy     = (state != IDLE);

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is live rxs.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else if (tick) begin
      if (phase == PH_S0) samp0 <= rxs;
      if (phase == PH_S1) samp1 <= rxs;
    end
  end

  // Frame state machine. START hands over to DATA at mid-start-bit, so the
  // first bit end seen in DATA belongs to the start bit; data_pend marks that
  // a data-bit majority has been captured and is due to shift at bit end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      bitcnt    <= '0;
      bit_val   <= 1'b0;
      data_pend <= 1'b0;
      shreg     <= '0;
    end else begin
      if (tick) phase <= (phase == PH_END) ? '0 : phase + 1'b1;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            phase <= '0;
          end
        end
        START: begin
          if (mid) begin
            if (maj) state <= IDLE;
            else begin
              state     <= DATA;
              bitcnt    <= '0;
              data_pend <= 1'b0;
            end
          end
        end
        DATA: begin
          if (mid) begin
            bit_val   <= maj;
            data_pend <= 1'b1;
          end
          if (bit_end && data_pend) begin
            shreg     <= {bit_val, shreg[DATA_BITS-1:1]};
            data_pend <= 1'b0;
            bitcnt    <= bitcnt + 1'b1;
            if (bitcnt == LASTBIT) state <= STOP;
          end
        end
        STOP: begin
          if (mid) begin
            if (maj) state <= IDLE;
            else begin
              state <= BREAK;
              phase <= '0;
            end
          end
        end
        BREAK: begin
          if (!rxs) phase <= '0;
          else if (bit_end) begin
            state <= IDLE;
            phase <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= load && rx_valid && !rx_ready;
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
